// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency 32-bit memory between instruction fetch (IF)
// and load/store (MA). Covers byte lanes, misalignment, IF/MA fairness and ack timeout.
module unified_mem_arbiter #(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned MA_BURST_MAX = 4,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_rdata_o,
   output logic              if_ready_o,
   output logic              if_err_o,
   input  logic              ma_re_i,
   input  logic              ma_we_i,
   input  logic [ADDR_W-1:0] ma_addr_i,
   input  logic [31:0]       ma_wdata_i,
   input  logic [1:0]        ma_store_type_i,
   output logic [31:0]       ma_rdata_o,
   output logic              ma_ready_o,
   output logic              ma_err_o,
   output logic              stall_if_o,
   output logic              stall_ma_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ack_i
);

   localparam int unsigned ToW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned FairW  = ($clog2(MA_BURST_MAX + 1) > 0) ? $clog2(MA_BURST_MAX + 1) : 1;
   localparam logic [ToW-1:0]   ToLast  = ToW'(TIMEOUT - 1);
   localparam logic [FairW-1:0] FairMax = FairW'(MA_BURST_MAX);

   typedef enum logic [1:0] {StIdle, StGrantIf, StGrantMa, StDone} state_e;

   state_e              state_q;
   logic [ToW-1:0]      to_cnt_q;
   logic [FairW-1:0]    fair_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic [3:0]          mem_be_q;
   logic [31:0]         if_rdata_q;
   logic [31:0]         ma_rdata_q;
   logic                if_ready_q;
   logic                ma_ready_q;
   logic                if_err_q;
   logic                ma_err_q;

   logic                ma_req;
   logic                pick_ma;
   logic                pick_if;
   logic [1:0]          ma_off;
   logic                ma_misaligned;
   logic [3:0]          ma_be;
   logic [31:0]         ma_lane_wdata;
   logic                unused_if_lsb;

   // Fetches are word aligned by contract; the low bits are dropped.
   assign unused_if_lsb = ^if_addr_i[1:0];

   assign ma_req  = ma_re_i | ma_we_i;
   assign pick_ma = ma_req & (~if_req_i | (fair_q < FairMax));
   assign pick_if = if_req_i & ~pick_ma;
   assign ma_off  = ma_addr_i[1:0];

   always_comb begin
      ma_misaligned = 1'b0;
      ma_be         = 4'b1111;
      ma_lane_wdata = ma_wdata_i;
      case (ma_store_type_i)
         2'b00: begin
            ma_be         = 4'b0001 << ma_off;
            ma_lane_wdata = {4{ma_wdata_i[7:0]}};
         end
         2'b01: begin
            ma_be         = 4'b0011 << ma_off;
            ma_lane_wdata = {2{ma_wdata_i[15:0]}};
            ma_misaligned = ma_off[0];
         end
         default: ma_misaligned = (ma_off != 2'b00);
      endcase
      // Loads always fetch the full word; the pipeline extracts the lane itself.
      if (!ma_we_i) begin
         ma_be         = 4'b1111;
         ma_lane_wdata = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         to_cnt_q    <= '0;
         fair_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         ma_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         ma_ready_q  <= 1'b0;
         if_err_q    <= 1'b0;
         ma_err_q    <= 1'b0;
      end else begin
         if_ready_q <= 1'b0;
         ma_ready_q <= 1'b0;
         if_err_q   <= 1'b0;
         ma_err_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               to_cnt_q <= '0;
               if (pick_ma) begin
                  if (if_req_i && (fair_q != FairMax)) begin
                     fair_q <= fair_q + 1'b1;
                  end
                  if (ma_misaligned) begin
                     state_q    <= StDone;
                     ma_ready_q <= 1'b1;
                     ma_err_q   <= 1'b1;
                     ma_rdata_q <= '0;
                  end else begin
                     state_q     <= StGrantMa;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= ma_we_i;
                     mem_addr_q  <= {ma_addr_i[ADDR_W-1:2], 2'b00};
                     mem_wdata_q <= ma_lane_wdata;
                     mem_be_q    <= ma_be;
                  end
               end else if (pick_if) begin
                  fair_q      <= '0;
                  state_q     <= StGrantIf;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= {if_addr_i[ADDR_W-1:2], 2'b00};
                  mem_wdata_q <= '0;
                  mem_be_q    <= 4'b1111;
               end
            end
            StGrantIf, StGrantMa: begin
               // An ack in the final timeout cycle still completes cleanly.
               if (mem_ack_i || (to_cnt_q == ToLast)) begin
                  state_q   <= StDone;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (state_q == StGrantIf) begin
                     if_ready_q <= 1'b1;
                     if_err_q   <= ~mem_ack_i;
                     if_rdata_q <= mem_ack_i ? mem_rdata_i : 32'h0;
                  end else begin
                     ma_ready_q <= 1'b1;
                     ma_err_q   <= ~mem_ack_i;
                     ma_rdata_q <= mem_ack_i ? mem_rdata_i : 32'h0;
                  end
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            StDone: state_q <= StIdle;
         endcase
      end
   end

   assign if_rdata_o  = if_rdata_q;
   assign if_ready_o  = if_ready_q;
   assign if_err_o    = if_err_q;
   assign ma_rdata_o  = ma_rdata_q;
   assign ma_ready_o  = ma_ready_q;
   assign ma_err_o    = ma_err_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;

   // Reset gates the stalls so the pipeline is released the moment reset asserts.
   assign stall_if_o = if_req_i & ~if_ready_q & ~reset_i;
   assign stall_ma_o = ma_req & ~ma_ready_q & ~reset_i;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency 32-bit memory between two requesters: instruction fetch (IF) and memory access (MA, loads and stores).
- Sits between the IF/MA pipeline stages and the memory macro.
- Produces per-port stall signals that feed the pipeline write-enable/hazard logic.
- Handles store byte-lane generation, misalignment rejection, fairness between ports and memory timeout.

Parameters:
ADDR_W, 16, byte address width (matches 16-bit PC)
MA_BURST_MAX, 4, consecutive MA grants allowed while IF waits before IF is forced
TIMEOUT, 64, cycles to wait for mem_ack before aborting

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch byte address (word aligned)
if_rdata  out  32  fetched instruction, valid with if_ready
if_ready  out  1  one-cycle completion pulse
ma_re  in  1  load request; held until ma_ready
ma_we  in  1  store request; held until ma_ready (ma_re and ma_we never both 1)
ma_addr  in  ADDR_W  data byte address
ma_wdata  in  32  store data, right-aligned
ma_store_type  in  2  00 byte, 01 half, 10 word (also size for loads)
ma_rdata  out  32  raw 32-bit memory word, valid with ma_ready
ma_ready  out  1  one-cycle completion pulse
ma_err  out  1  with ma_ready: misaligned or timeout
if_err  out  1  with if_ready: timeout
stall_IF  out  1  if_req & ~if_ready
stall_MA  out  1  (ma_re|ma_we) & ~ma_ready
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
mem_wdata  out  32  lane-shifted store data
mem_be  out  4  byte enables
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  completion, one cycle

Behaviour:
- Reset: state IDLE. All outputs 0, timeout counter 0, fairness counter 0. Async reset mid-transaction drops mem_req immediately and produces no ready pulse. Memory discards the abandoned access.
- FSM states: IDLE, GRANT_IF, GRANT_MA, DONE.
- IDLE arbitration, per cycle:
  - MA requesting and (no IF request or fairness count < MA_BURST_MAX): go to GRANT_MA.
  - Otherwise, IF requesting: go to GRANT_IF.
  - On transition, register the address, we, wdata and be.
- Fairness counter:
  - Increments on each MA grant taken while if_req is high.
  - Clears on IF grant.
  - Saturates at MA_BURST_MAX.
- Misaligned MA access (half with addr[0]=1, or word with addr[1:0]≠0):
  - No memory cycle.
  - IDLE goes directly to DONE.
  - ma_ready=1, ma_err=1, ma_rdata=0.
- Byte lanes, with o = addr[1:0]:
  - byte: be = 0001<<o, wdata = {4{byte}}.
  - half: be = 0011<<o, wdata = {2{half}}.
  - word: be = 1111.
  - Loads drive be=1111 and mem_we=0.
- GRANT_x:
  - mem_req=1 with stable registered address, we, wdata and be. The first mem_req cycle is the cycle after the grant decision.
  - On mem_ack: capture mem_rdata, go to DONE.
  - Timeout counter counts cycles in GRANT_x. If it reaches TIMEOUT-1 without ack, go to DONE with err=1 and rdata=0.
  - mem_ack arriving in the same cycle as the timeout: ack wins, no error.
- DONE (exactly one cycle):
  - The granted port's ready=1 and err as set. Registered rdata is held.
  - mem_req=0.
  - Next state IDLE. No arbitration in DONE, so a requester deasserting after ready is never re-granted.
- Minimum latency: request seen in cycle N, mem_req in N+1, ack in N+1, ready in N+2, next grant decision in N+3.
- mem_ack outside GRANT_x is ignored.
- if_rdata and ma_rdata hold their last value until overwritten.
- stall_IF and stall_MA are combinational from the inputs and registered ready.

Test Plan:
- Single fetch, zero-wait memory: if_req=1, if_addr=0x0010, mem_ack in first mem_req cycle with rdata=0x00500093 -> mem_addr=0x0010, if_ready pulses at N+2 with if_rdata=0x00500093, stall_IF high N..N+1.
- Simultaneous requests: if_req and ma_re (addr 0x0104, word) both at N -> MA served first (mem_addr=0x0104), then IF. With MA re-requesting continuously, IF is granted after 4 MA grants.
- Byte store: ma_we=1, addr=0x0203, type=00, wdata=0x000000AB -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x0200, mem_we=1. Half store at 0x0202 -> be=1100.
- Misaligned word load at 0x0102 -> no mem_req, ma_ready=ma_err=1 at N+1, ma_rdata=0.
- Timeout: never assert mem_ack on an IF grant -> if_ready=if_err=1 after 64 cycles of mem_req, if_rdata=0. Ack on the 64th cycle -> no error.
- Reset mid-op: assert reset while mem_req=1 -> mem_req, ready and stall outputs go to 0 immediately (asynchronously). After release, a pending if_req is granted from IDLE.
